// File: rtl/dff_pkg.sv
// Shared types and helpers for the DFF stream checker slice.
package dff_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      REPORT = 2'd3
   } chk_state_e;

   // Report record at the default counter width; software and bench views use it.
   localparam int REP_W = 16;

   typedef struct packed {
      logic [REP_W-1:0] checked;
      logic [REP_W-1:0] mismatches;
      logic [REP_W-1:0] first_err;
   } chk_report_t;

   // All-ones "no error seen" marker for a counter of cnt_w bits (cnt_w <= 32).
   function automatic logic [31:0] no_err(input int cnt_w);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < 32; i++) begin
         if (i < cnt_w) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/dff_param_check.sv
// Elaboration-time range checks on the checker parameters.
module dff_param_check #(
   parameter int LATENCY = 1,
   parameter int WINDOW  = 256,
   parameter int CNT_W   = 16
) ();

   if (LATENCY < 1) begin : g_bad_latency
      $error("dff_stream_checker: LATENCY must be >= 1");
   end

   if (CNT_W < 2 || CNT_W > 32) begin : g_bad_cnt_w
      $error("dff_stream_checker: CNT_W must be in 2..32");
   end

   if (WINDOW < 1 || longint'(WINDOW) > ((longint'(1) << CNT_W) - longint'(2))) begin : g_bad_window
      $error("dff_stream_checker: WINDOW must be in 1..2^CNT_W-2");
   end

endmodule

// File: rtl/dff_ref_pipe.sv
// LATENCY-deep expected-value delay line; a DFF reset forces a 0 into the head.
module dff_ref_pipe #(
   parameter int LATENCY = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   input  logic dut_rst,
   output logic expected
);

   logic [LATENCY-1:0] stage_r;

   // Shift every cycle regardless of checker state so history is always valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r <= '0;
      end else begin
         stage_r[0] <= dut_rst ? 1'b0 : din;
         for (int i = 1; i < LATENCY; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign expected = stage_r[LATENCY-1];

endmodule

// File: rtl/dff_stream_checker.sv
// Hardware response checker for the DFF: compares dout against a delayed din
// model over a fixed window and returns one summary record via valid/ready.
module dff_stream_checker
   import dff_pkg::*;
#(
   parameter int LATENCY = 1,
   parameter int WINDOW  = 256,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din_tap,
   input  logic             dut_rst_tap,
   input  logic             dout,
   output logic             busy,
   output logic             report_valid,
   input  logic             report_ready,
   output logic [CNT_W-1:0] report_checked,
   output logic [CNT_W-1:0] report_mismatches,
   output logic [CNT_W-1:0] report_first_err
);

   localparam logic [CNT_W-1:0] NO_ERR = CNT_W'(no_err(CNT_W));
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   chk_state_e       state_r, state_nx_s;
   logic [31:0]      cnt_r, cnt_nx_s;
   logic [CNT_W-1:0] idx_r, idx_nx_s;
   logic [CNT_W-1:0] mism_r, mism_nx_s;
   logic [CNT_W-1:0] first_r, first_nx_s;
   logic             expected_s;
   logic             compare_s;
   logic             mismatch_s;
   logic             busy_r, valid_r;
   logic [CNT_W-1:0] rep_checked_r, rep_mism_r, rep_first_r;

   dff_param_check #(
      .LATENCY (LATENCY),
      .WINDOW  (WINDOW),
      .CNT_W   (CNT_W)
   ) u_param_check ();

   dff_ref_pipe #(
      .LATENCY (LATENCY)
   ) u_ref_pipe (
      .clk      (clk),
      .rst      (rst),
      .din      (din_tap),
      .dut_rst  (dut_rst_tap),
      .expected (expected_s)
   );

   // Next-state and shared SETTLE/CHECK down-counter.
   always_comb begin
      state_nx_s = state_r;
      cnt_nx_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = SETTLE;
               cnt_nx_s   = 32'(LATENCY - 1);
            end else begin
               state_nx_s = IDLE;
            end
         end
         SETTLE: begin
            if (cnt_r == 32'd0) begin
               state_nx_s = CHECK;
               cnt_nx_s   = 32'(WINDOW - 1);
            end else begin
               cnt_nx_s   = cnt_r - 32'd1;
            end
         end
         CHECK: begin
            if (cnt_r == 32'd0) begin
               state_nx_s = REPORT;
            end else begin
               cnt_nx_s   = cnt_r - 32'd1;
            end
         end
         REPORT: begin
            if (report_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = REPORT;
            end
         end
         default: begin
            state_nx_s = IDLE;
            cnt_nx_s   = 32'd0;
         end
      endcase
   end

   // Compare and counter updates; case inequality so X/Z on dout is a failure.
   always_comb begin
      compare_s  = (state_r == CHECK);
      mismatch_s = compare_s && (dout !== expected_s);
      idx_nx_s   = compare_s ? (idx_r + ONE) : idx_r;
      mism_nx_s  = mismatch_s ? (mism_r + ONE) : mism_r;
      if (mismatch_s && (mism_r == '0)) begin
         first_nx_s = idx_r;
      end else begin
         first_nx_s = first_r;
      end
   end

   // State, run counters, status flags and the held report record.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         cnt_r         <= 32'd0;
         idx_r         <= '0;
         mism_r        <= '0;
         first_r       <= NO_ERR;
         busy_r        <= 1'b0;
         valid_r       <= 1'b0;
         rep_checked_r <= '0;
         rep_mism_r    <= '0;
         rep_first_r   <= NO_ERR;
      end else begin
         state_r <= state_nx_s;
         cnt_r   <= cnt_nx_s;
         busy_r  <= (state_nx_s != IDLE);
         valid_r <= (state_nx_s == REPORT);
         if ((state_r == IDLE) && start) begin
            idx_r   <= '0;
            mism_r  <= '0;
            first_r <= NO_ERR;
         end else begin
            idx_r   <= idx_nx_s;
            mism_r  <= mism_nx_s;
            first_r <= first_nx_s;
         end
         // The record is captured once, on the last compare, and held through REPORT.
         if (compare_s && (state_nx_s == REPORT)) begin
            rep_checked_r <= idx_nx_s;
            rep_mism_r    <= mism_nx_s;
            rep_first_r   <= first_nx_s;
         end else begin
            rep_checked_r <= rep_checked_r;
            rep_mism_r    <= rep_mism_r;
            rep_first_r   <= rep_first_r;
         end
      end
   end

   assign busy              = busy_r;
   assign report_valid      = valid_r;
   assign report_checked    = rep_checked_r;
   assign report_mismatches = rep_mism_r;
   assign report_first_err  = rep_first_r;

endmodule

// File: tb/tb_dff_stream_checker.sv
// Directed bench: one checker at LATENCY=1 and one at LATENCY=3, both WINDOW=8,
// driven by a behavioural DFF plant with fault injection.
module tb_dff_stream_checker;
   import dff_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start1, start3, din_tap, dut_rst_tap, report_ready;
   logic dout1, dout3;
   logic busy1, valid1, busy3, valid3;
   logic [15:0] chk1, mis1, fe1, chk3, mis3, fe3;

   dff_stream_checker #(.LATENCY(1), .WINDOW(8), .CNT_W(16)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .din_tap(din_tap), .dut_rst_tap(dut_rst_tap),
      .dout(dout1), .busy(busy1), .report_valid(valid1), .report_ready(report_ready),
      .report_checked(chk1), .report_mismatches(mis1), .report_first_err(fe1)
   );

   dff_stream_checker #(.LATENCY(3), .WINDOW(8), .CNT_W(16)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .din_tap(din_tap), .dut_rst_tap(dut_rst_tap),
      .dout(dout3), .busy(busy3), .report_valid(valid3), .report_ready(report_ready),
      .report_checked(chk3), .report_mismatches(mis3), .report_first_err(fe3)
   );

   // Behavioural DFF plant: 1-stage and 3-stage, optionally deaf to its reset.
   logic stuck0, ign_rst, inv_now, sel;
   logic q1 = 1'b0;
   logic [2:0] q3 = 3'b000;

   always @(posedge clk) begin
      q1 <= (dut_rst_tap && !ign_rst) ? 1'b0 : din_tap;
      q3 <= {q3[1:0], (dut_rst_tap && !ign_rst) ? 1'b0 : din_tap};
   end

   assign dout1 = stuck0 ? 1'b0 : (q1 ^ inv_now);
   assign dout3 = stuck0 ? 1'b0 : (q3[2] ^ inv_now);

   logic busy_m, valid_m;
   logic [15:0] chk_m, mis_m, fe_m;
   always_comb begin
      busy_m  = sel ? busy3  : busy1;
      valid_m = sel ? valid3 : valid1;
      chk_m   = sel ? chk3   : chk1;
      mis_m   = sel ? mis3   : mis1;
      fe_m    = sel ? fe3    : fe1;
   end

   typedef struct {
      logic [7:0]  din;
      logic [7:0]  rstm;
      logic [7:0]  invm;
      logic        stuck;
      logic        ign;
      chk_report_t exp;
   } vec_t;

   vec_t vt [7];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full run; bit k of din/rstm feeds compare k, bit k of invm flips dout at compare k.
   task automatic run(input string tag, input vec_t v, input int lat, input int hold);
      stuck0  = v.stuck;
      ign_rst = v.ign;
      inv_now = 1'b0;
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk); @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      chk({tag, " busy_at_start"}, 32'(busy_m), 32'd1);
      for (int i = 0; i < lat + 8; i++) begin
         if (i < 8) begin
            din_tap     = v.din[i];
            dut_rst_tap = v.rstm[i];
         end else begin
            din_tap     = 1'b0;
            dut_rst_tap = 1'b0;
         end
         if (i >= lat) inv_now = v.invm[i-lat];
         else          inv_now = 1'b0;
         if (i == lat + 7) chk({tag, " valid_early"}, 32'(valid_m), 32'd0);
         @(posedge clk); @(negedge clk);
      end
      inv_now = 1'b0;
      chk({tag, " valid"},      32'(valid_m), 32'd1);
      chk({tag, " checked"},    32'(chk_m),   32'(v.exp.checked));
      chk({tag, " mismatches"}, 32'(mis_m),   32'(v.exp.mismatches));
      chk({tag, " first_err"},  32'(fe_m),    32'(v.exp.first_err));
      for (int j = 0; j < hold; j++) begin
         if (j == 2) begin
            if (sel) start3 = 1'b1; else start1 = 1'b1;
         end
         @(posedge clk); @(negedge clk);
         start1 = 1'b0; start3 = 1'b0;
         chk({tag, " hold_valid"}, 32'(valid_m), 32'd1);
         chk({tag, " hold_fields"}, {chk_m[7:0], mis_m[7:0], fe_m},
             {v.exp.checked[7:0], v.exp.mismatches[7:0], v.exp.first_err});
      end
      report_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      report_ready = 1'b0;
      chk({tag, " valid_drop"}, 32'(valid_m), 32'd0);
      chk({tag, " busy_drop"},  32'(busy_m),  32'd0);
   endtask

   // Failing run interrupted by rst just before compare 4.
   task automatic rst_mid(input string tag, input int lat);
      logic saw_valid;
      stuck0 = 1'b1; ign_rst = 1'b0; inv_now = 1'b0; din_tap = 1'b1;
      if (sel) start3 = 1'b1; else start1 = 1'b1;
      @(posedge clk); @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      for (int i = 0; i < lat + 4; i++) begin
         @(posedge clk); @(negedge clk);
      end
      chk({tag, " busy_mid_run"}, 32'(busy_m), 32'd1);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      chk({tag, " rst_busy"},    32'(busy_m),  32'd0);
      chk({tag, " rst_valid"},   32'(valid_m), 32'd0);
      chk({tag, " rst_checked"}, 32'(chk_m),   32'd0);
      chk({tag, " rst_mism"},    32'(mis_m),   32'd0);
      chk({tag, " rst_first"},   32'(fe_m),    32'h0000FFFF);
      saw_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); @(negedge clk);
         if (valid_m || busy_m) saw_valid = 1'b1;
      end
      chk({tag, " no_partial_report"}, 32'(saw_valid), 32'd0);
      stuck0 = 1'b0; din_tap = 1'b0;
   endtask

   initial begin
      rst = 1'b1; start1 = 1'b0; start3 = 1'b0; din_tap = 1'b0; dut_rst_tap = 1'b0;
      report_ready = 1'b0; stuck0 = 1'b0; ign_rst = 1'b0; inv_now = 1'b0; sel = 1'b0;

      vt[0] = '{8'h4D, 8'h00, 8'h00, 1'b0, 1'b0, '{16'd8, 16'd0, 16'hFFFF}};
      vt[1] = '{8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, '{16'd8, 16'd8, 16'd0}};
      vt[2] = '{8'h4D, 8'h00, 8'h20, 1'b0, 1'b0, '{16'd8, 16'd1, 16'd5}};
      vt[3] = '{8'hFF, 8'h08, 8'h00, 1'b0, 1'b0, '{16'd8, 16'd0, 16'hFFFF}};
      vt[4] = '{8'hFF, 8'h08, 8'h00, 1'b0, 1'b1, '{16'd8, 16'd1, 16'd3}};
      vt[5] = '{8'hA5, 8'h00, 8'h81, 1'b0, 1'b0, '{16'd8, 16'd2, 16'd0}};
      vt[6] = '{8'h3C, 8'h00, 8'h01, 1'b0, 1'b0, '{16'd8, 16'd1, 16'd0}};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset busy1",  32'(busy1),  32'd0);
      chk("reset valid1", 32'(valid1), 32'd0);
      chk("reset chk1",   32'(chk1),   32'd0);
      chk("reset mis1",   32'(mis1),   32'd0);
      chk("reset fe1",    32'(fe1),    32'h0000FFFF);
      chk("reset busy3",  32'(busy3),  32'd0);
      chk("reset fe3",    32'(fe3),    32'h0000FFFF);
      rst = 1'b0;
      @(negedge clk);

      sel = 1'b0;
      for (int i = 0; i < 6; i++) begin
         run($sformatf("L1 vec%0d", i), vt[i], 1, 0);
      end
      run("L1 hold", vt[0], 1, 5);
      run("L1 restart", vt[2], 1, 0);
      rst_mid("L1 rstmid", 1);

      sel = 1'b1;
      run("L3 ideal", vt[0], 3, 0);
      run("L3 inv5", vt[2], 3, 0);
      run("L3 inv0", vt[6], 3, 0);
      run("L3 dutrst", vt[4], 3, 0);
      rst_mid("L3 rstmid", 3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
